rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter MAX_HOLD, default 15: maximum consecutive cycles one requester may hold a grant; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  arbiter enable; 0 forces all grants off.
REQ-005 req  input  4  request lines, bit i = requester i, active-high, level-sensitive.
REQ-006 done  input  1  current grant holder releases the resource this cycle.
REQ-007 gnt_n  output  4  grant lines, active-low, at most one bit low; 4'b1111 = no grant.
REQ-008 gnt_id  output  2  index of current grantee; valid only while busy=1.
REQ-009 busy  output  1  high while any grant is active.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The block SHALL implement the FSM states IDLE, GRANT and GAP.
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 IDLE: if en=1 and req!=0, the next state SHALL be GRANT, with the winner on gnt_n/gnt_id/busy one cycle after req is sampled.
REQ-014 Winner selection SHALL be round-robin: search order starts at (last_id+1) mod 4 and wraps; the first requester found with req bit set wins.
REQ-015 last_id SHALL update to the winner's index on entry to GRANT.
REQ-016 GRANT: a hold counter SHALL start at 0 on entry and increment by 1 each cycle, with width ceil(log2(MAX_HOLD+1)) bits.
REQ-017 GRANT SHALL exit to GAP on the first cycle meeting any of: done=1, req[gnt_id]=0, en=0, or hold counter = MAX_HOLD-1.
REQ-018 When several exit conditions coincide, the block SHALL take one exit; timeout SHALL pulse only if done=0, req[gnt_id]=1, en=1 and the counter limit was reached.
REQ-019 GAP SHALL last exactly one cycle with gnt_n=4'b1111 and busy=0, then go to IDLE; this provides break-before-make between grantees.
REQ-020 In IDLE and GAP, gnt_n SHALL be 4'b1111, busy=0, and gnt_id SHALL hold its last value.
REQ-021 A done pulse while not in GRANT SHALL be ignored.
REQ-022 A requester that loses its grant by timeout while still requesting SHALL rejoin arbitration at lowest priority, because last_id equals its index.
REQ-023 With en=0 the FSM SHALL remain in IDLE; en rising SHALL start arbitration on the next cycle with no lost pointer state.
REQ-024 gnt_n SHALL equal ~(4'b0001 << gnt_id) whenever busy=1.

Reset
REQ-025 On rst high, the block SHALL immediately set state=IDLE, gnt_n=4'b1111, gnt_id=2'b00, busy=0, timeout=0, hold counter=0, last_id=2'd3, so that requester 0 has first priority.
REQ-026 Reset asserted mid-grant SHALL drop the grant asynchronously, without passing through GAP.
REQ-027 After rst deasserts, the first grant SHALL occur no earlier than the second rising edge of clk.

Structure
REQ-028 The state encodings (IDLE=2'd0, GRANT=2'd1, GAP=2'd2) and the default MAX_HOLD SHALL live in the shared comparch package/include file.
REQ-029 The round-robin priority search SHALL be a combinational sub-module rr_pick4, with inputs req[3:0] and last_id[1:0] and outputs any and win_id[1:0].
REQ-030 No other sub-modules are required.

Verification
REQ-031 After reset, req=4'b1111 held with done pulsed each grant -> grants go to 0,1,2,3,0 with a one-cycle gnt_n=4'b1111 gap between each.
REQ-032 req=4'b0100 only, no done, MAX_HOLD=15 -> gnt_n=4'b1011 for exactly 15 cycles, timeout pulses once, GAP, then regrant to 2.
REQ-033 Grant to 1 active, req=4'b1010, done=1 -> next grant goes to 3, not 1.
REQ-034 Grant active, en dropped to 0 -> GAP next cycle, no timeout pulse, no further grants while en=0.
REQ-035 rst asserted mid-grant between clock edges -> gnt_n=4'b1111 and busy=0 immediately; after release with req=4'b1001, the first grant goes to 0.
REQ-036 done=1 and counter limit reached in the same cycle -> exit to GAP with timeout=0.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding,
// default hold limit and reset pointer.
package rr_arbiter_4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int MAX_HOLD_DEF = 15;

  // Pointer resets to 3 so requester 0 is searched first.
  localparam logic [1:0] LAST_ID_RST = 2'd3;

  function automatic logic [3:0] grant_lines(input logic [1:0] id);
    return ~(4'b0001 << id);
  endfunction

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// Combinational round-robin pick: searches from (last_id+1) mod 4 upward,
// wrapping, and reports the first set request.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last_id,
  output logic       any,
  output logic [1:0] win_id
);

  logic [1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit lands last.
  always_comb begin
    any    = |req;
    win_id = last_id;
    idx    = last_id;
    for (int k = 4; k >= 1; k--) begin
      idx = last_id + k[1:0];
      if (req[idx]) win_id = idx;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with active-low grants, a hold limit
// with timeout pulse, and a one-cycle break-before-make gap.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt_n,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] LIMIT = HW'(MAX_HOLD - 1);

  state_t        state, state_d;
  logic [HW-1:0] hold, hold_d;
  logic [1:0]    last_id, last_d;
  logic          armed;
  logic [3:0]    gnt_n_d;
  logic [1:0]    gnt_id_d;
  logic          busy_d, timeout_d;
  logic          any;
  logic [1:0]    win_id;
  logic          limit, still_req;

  rr_pick4 u_pick (
    .req     (req),
    .last_id (last_id),
    .any     (any),
    .win_id  (win_id)
  );

  assign limit     = (hold == LIMIT);
  assign still_req = req[gnt_id];

  // armed blocks arbitration on the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hold    <= '0;
      last_id <= LAST_ID_RST;
      armed   <= 1'b0;
      gnt_n   <= 4'b1111;
      gnt_id  <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      hold    <= hold_d;
      last_id <= last_d;
      armed   <= 1'b1;
      gnt_n   <= gnt_n_d;
      gnt_id  <= gnt_id_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    hold_d    = hold;
    last_d    = last_id;
    gnt_n_d   = 4'b1111;
    gnt_id_d  = gnt_id;
    busy_d    = 1'b0;
    timeout_d = 1'b0;
    case (state)
      IDLE: begin
        if (armed && en && any) begin
          state_d  = GRANT;
          hold_d   = '0;
          last_d   = win_id;
          gnt_id_d = win_id;
          gnt_n_d  = grant_lines(win_id);
          busy_d   = 1'b1;
        end
      end
      GRANT: begin
        if (done || !still_req || !en || limit) begin
          state_d   = GAP;
          hold_d    = '0;
          timeout_d = !done && still_req && en && limit;
        end else begin
          hold_d  = hold + 1'b1;
          gnt_n_d = gnt_n;
          busy_d  = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: vector table, directed corner sequences and a
// randomized run against a cycle-level reference model.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst, en, done;
  logic [3:0] req;
  logic [3:0] gnt_n;
  logic [1:0] gnt_id;
  logic       busy, timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt_n   (gnt_n),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  // Reference model: who owns the resource, how many cycles it has been
  // visibly granted, whether the gap cycle is pending, and the pointer.
  int m_owner, m_held, m_last, m_id;
  bit m_gap, m_armed, m_to;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 3; m_id = 0;
    m_gap = 0; m_armed = 0; m_to = 0;
  endtask

  task automatic model_step();
    m_to = 0;
    if (m_owner >= 0) begin
      if (done || !req[m_owner] || !en || m_held == MAX_HOLD) begin
        m_to    = !done && req[m_owner] && en && (m_held == MAX_HOLD);
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_armed && en && req != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_owner < 0 && req[c]) m_owner = c;
      end
      m_last = m_owner;
      m_id   = m_owner;
      m_held = 1;
    end
    m_armed = 1;
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] one;
    logic [3:0] g;
    logic [1:0] id;
    one = 4'b0001;
    g   = (m_owner >= 0) ? ~(one << m_owner) : 4'b1111;
    id  = m_id[1:0];
    return {g, id, (m_owner >= 0), m_to};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_out();
    return {gnt_n, gnt_id, busy, timeout};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_out(), model_out());
  endtask

  // Asserts reset between edges, checks the immediate effect, releases mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_state", dut_out(), {4'b1111, 2'd0, 1'b0, 1'b0});
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt_n;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_len, to_cnt, to_pos;
    logic [3:0] g_hist[18];
    logic       t_hist[18];
    bit         any_busy;

    rst = 1'b0; en = 1'b0; req = 4'b0000; done = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Full request with done each grant: 0,1,2,3,0; done outside GRANT ignored.
    tbl[0]  = '{1'b1, 4'hF, 1'b0, 4'hF, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 1'b0, 4'hE, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, 1'b0, 4'hF, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 1'b0, 4'hD, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 4'hF, 1'b1, 4'hF, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 4'hF, 1'b0, 4'hF, 2'd1, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, 1'b0, 4'hB, 2'd2, 1'b1};
    tbl[8]  = '{1'b1, 4'hF, 1'b1, 4'hF, 2'd2, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, 1'b1, 4'hF, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 4'hF, 1'b0, 4'h7, 2'd3, 1'b1};
    tbl[11] = '{1'b1, 4'hF, 1'b1, 4'hF, 2'd3, 1'b0};
    tbl[12] = '{1'b1, 4'hF, 1'b0, 4'hF, 2'd3, 1'b0};
    tbl[13] = '{1'b1, 4'hF, 1'b1, 4'hE, 2'd0, 1'b1};
    tbl[14] = '{1'b1, 4'hF, 1'b1, 4'hF, 2'd0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; req = tbl[i].req; done = tbl[i].done;
      step();
      check($sformatf("vec%0d", i), dut_out(), {tbl[i].gnt_n, tbl[i].id, tbl[i].busy, 1'b0});
    end
    done = 1'b0;

    // Single requester held past the limit.
    do_reset();
    en = 1'b1; req = 4'b0100; done = 1'b0;
    step();
    for (int i = 0; i < 18; i++) begin
      step();
      g_hist[i] = gnt_n;
      t_hist[i] = timeout;
    end
    run_len = 0; to_cnt = 0; to_pos = -1;
    for (int i = 0; i < 18; i++) begin
      if (g_hist[i] == 4'b1011 && run_len == i) run_len++;
      if (t_hist[i]) begin to_cnt++; to_pos = i; end
    end
    check("hold_len", 8'(run_len), 8'd15);
    check("timeout_cnt", 8'(to_cnt), 8'd1);
    check("timeout_pos", 8'(to_pos), 8'd15);
    check("gap_after_to", {4'b0, g_hist[15]}, 8'h0F);
    check("regrant2", {4'b0, g_hist[17]}, 8'h0B);

    // Grant to 1, then done with req=1010: next goes to 3.
    do_reset();
    en = 1'b1; req = 4'b0010;
    step(); step();
    check("grant1", dut_out(), {4'b1101, 2'd1, 1'b1, 1'b0});
    req = 4'b1010; done = 1'b1;
    step();
    done = 1'b0;
    step(); step();
    check("next_is_3", dut_out(), {4'b0111, 2'd3, 1'b1, 1'b0});

    // en dropped mid-grant: gap without timeout, no grants while low, pointer kept.
    do_reset();
    en = 1'b1; req = 4'b0001;
    step(); step();
    check("grant0_en", dut_out(), {4'b1110, 2'd0, 1'b1, 1'b0});
    en = 1'b0;
    step();
    check("en_drop", dut_out(), {4'b1111, 2'd0, 1'b0, 1'b0});
    any_busy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      any_busy |= busy;
    end
    check("en_low_quiet", {7'b0, any_busy}, 8'h00);
    en = 1'b1; req = 4'b0011;
    step();
    check("en_resume", dut_out(), {4'b1101, 2'd1, 1'b1, 1'b0});

    // Reset mid-grant after a grant to 0: pointer must return to 3.
    do_reset();
    en = 1'b1; req = 4'b0001;
    step(); step();
    check("pre_rst_grant0", dut_out(), {4'b1110, 2'd0, 1'b1, 1'b0});
    req = 4'b1001;
    do_reset();
    step();
    check("post_rst_wait", {7'b0, busy}, 8'h00);
    step();
    check("post_rst_grant0", dut_out(), {4'b1110, 2'd0, 1'b1, 1'b0});

    // done coinciding with the hold limit: no timeout.
    do_reset();
    en = 1'b1; req = 4'b0100; done = 1'b0;
    step(); step();
    repeat (14) step();
    check("at_limit", dut_out(), {4'b1011, 2'd2, 1'b1, 1'b0});
    done = 1'b1;
    step();
    check("done_at_limit", dut_out(), {4'b1111, 2'd2, 1'b0, 1'b0});
    done = 1'b0;

    // Randomized traffic with sticky requests so timeouts occur.
    do_reset();
    req = 4'($urandom);
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 19) != 0);
      done = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) req = 4'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
